// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RISC-V control FSM:
// state encoding, legal opcode constants, ALU op codes and trap causes.
package multicycle_controller_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_controller_insn_class_decode.sv
// insn_class_decode: combinational opcode -> instruction class.
// Ports:
//   opcode     in  7  instruction[6:0]
//   is_r .. is_branch out  one-hot class flags for the legal opcodes
//   illegal    out 1  opcode is none of the supported classes
module insn_class_decode
   import multicycle_controller_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       is_r,
   output logic       is_i,
   output logic       is_load,
   output logic       is_store,
   output logic       is_branch,
   output logic       illegal
);

   always_comb begin
      is_r      = (opcode == OP_R);
      is_i      = (opcode == OP_I);
      is_load   = (opcode == OP_LOAD);
      is_store  = (opcode == OP_STORE);
      is_branch = (opcode == OP_BRANCH);
      illegal   = !(is_r || is_i || is_load || is_store || is_branch);
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle control FSM for the RISC-V core.
// Sequences IDLE/FETCH/DECODE/EXECUTE/MEM/WB over a ready-handshaked memory
// port, traps on illegal opcodes and memory timeouts, counts retirements.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, halt                    run control (halt has priority)
//   opcode, funct3, funct7, rd     instruction fields, sampled in DECODE
//   mem_ready, branch_taken        memory handshake, branch condition
//   mem_req, mem_we                memory request / store select
//   ir_we, pc_we, pc_sel           IR and PC update controls
//   reg_we, wb_sel, alu_src_b      datapath controls
//   alu_op                         ALU operation code
//   busy, trap, trap_cause         status
//   instret                        retired-instruction count (wraps)
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic [4:0]       rd,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             alu_src_b,
   output logic [3:0]       alu_op,
   output logic             busy,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t            state, nxt;
   logic [6:0]        op_q;
   logic [2:0]        f3_q;
   logic [6:0]        f7_q;
   logic [4:0]        rd_q;
   logic [1:0]        cause_q, nxt_cause;
   logic [CNT_W-1:0]  instret_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              retire;
   logic              timeout;
   logic [6:0]        dec_op;
   logic              is_r, is_i, is_load, is_store, is_branch, illegal;
   logic              unused_f7;

   assign unused_f7 = ^{f7_q[6], f7_q[4:0]};

   // DECODE classifies the live opcode; later states use the latched copy.
   assign dec_op = (state == S_DECODE) ? opcode : op_q;

   insn_class_decode u_dec (
      .opcode    (dec_op),
      .is_r      (is_r),
      .is_i      (is_i),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .illegal   (illegal)
   );

   // Final permitted wait cycle with no ready; a ready in this cycle still wins.
   assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         f3_q      <= '0;
         f7_q      <= '0;
         rd_q      <= '0;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
         wait_cnt  <= '0;
      end else begin
         state   <= nxt;
         cause_q <= nxt_cause;
         if (state == S_DECODE) begin
            op_q <= opcode;
            f3_q <= funct3;
            f7_q <= funct7;
            rd_q <= rd;
         end
         if (retire) instret_q <= instret_q + 1'b1;
         // Counter is zero whenever a request phase is entered, since it
         // clears on every cycle outside a stalled request.
         if ((state == S_FETCH || state == S_MEM) && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
      end
   end

   always_comb begin
      nxt       = state;
      nxt_cause = cause_q;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      case (state)
         S_IDLE: begin
            if (start && !halt) nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               nxt   = S_DECODE;
            end else if (timeout) begin
               nxt       = S_TRAP;
               nxt_cause = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               nxt       = S_TRAP;
               nxt_cause = CAUSE_ILLEGAL;
            end else begin
               nxt = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_src_b = is_i || is_load || is_store;
            if (is_r)
               alu_op = {f7_q[5], f3_q};
            else if (is_i)
               alu_op = {(f3_q == 3'b101) & f7_q[5], f3_q};
            else if (is_branch)
               alu_op = ALU_SUB;
            if (is_branch) begin
               pc_we  = 1'b1;
               pc_sel = branch_taken;
               retire = 1'b1;
               nxt    = halt ? S_IDLE : S_FETCH;
            end else if (is_r || is_i) begin
               nxt = S_WB;
            end else begin
               nxt = S_MEM;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
                  nxt    = halt ? S_IDLE : S_FETCH;
               end else begin
                  nxt = S_WB;
               end
            end else if (timeout) begin
               nxt       = S_TRAP;
               nxt_cause = CAUSE_TIMEOUT;
            end
         end
         S_WB: begin
            reg_we = (rd_q != 5'd0);
            wb_sel = is_load;
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = halt ? S_IDLE : S_FETCH;
         end
         S_TRAP: begin
            nxt = S_TRAP;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
   end

   assign busy       = (state != S_IDLE);
   assign trap       = (state == S_TRAP);
   assign trap_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is played
// as a script of expected per-cycle outputs derived from the instruction's
// class and handshake timing; one compare process checks every cycle.
module tb_multicycle_controller;

   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 4;
   localparam int          WRAP = 16;

   logic          clk, rst_n, start, halt;
   logic [6:0]    opcode, funct7;
   logic [2:0]    funct3;
   logic [4:0]    rd;
   logic          mem_ready, branch_taken;
   logic          mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b;
   logic [3:0]    alu_op;
   logic          busy, trap;
   logic [1:0]    trap_cause;
   logic [CW-1:0] instret;

   multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
      .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .busy(busy), .trap(trap), .trap_cause(trap_cause),
      .instret(instret)
   );

   typedef struct packed {
      logic       mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b;
      logic [3:0] alu_op;
      logic       busy, trap;
      logic [1:0] trap_cause;
      logic [3:0] instret;
   } obs_t;

   typedef enum int {K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_ILL} kind_t;

   int   checks = 0;
   int   errors = 0;
   obs_t exp_o;
   bit   exp_valid = 0;
   int   m_instret = 0;
   int   m_cause = 0;
   int   where = 0;   // 0 idle, 1 about to fetch, 2 trapped

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      return {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b,
              alu_op, busy, trap, trap_cause, instret};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (exp_valid) begin
            checks++;
            if (sample() !== exp_o) begin
               errors++;
               $display("FAIL cycle_outputs t=%0t got=%b required=%b", $time, sample(), exp_o);
            end
            exp_valid = 0;
         end
      end
   end

   task automatic lit(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   function automatic obs_t base();
      obs_t e;
      e = '0;
      e.busy       = 1'b1;
      e.trap_cause = 2'(m_cause);
      e.instret    = 4'(m_instret);
      return e;
   endfunction

   function automatic kind_t kind_of(input logic [6:0] op);
      case (op)
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b1100011: return K_BRANCH;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input kind_t k, input logic [2:0] f3, input logic [6:0] f7);
      case (k)
         K_R:      return {f7[5], f3};
         K_I:      return {(f3 == 3'd5) ? f7[5] : 1'b0, f3};
         K_BRANCH: return 4'b1000;
         default:  return 4'b0000;
      endcase
   endfunction

   task automatic begin_cycle();
      @(negedge clk);
      start        = 1'($urandom);
      halt         = 1'($urandom);
      mem_ready    = 1'($urandom);
      branch_taken = 1'($urandom);
      opcode       = 7'($urandom);
      funct3       = 3'($urandom);
      funct7       = 7'($urandom);
      rd           = 5'($urandom);
   endtask

   task automatic expect_now(input obs_t e);
      exp_o     = e;
      exp_valid = 1;
   endtask

   task automatic retire();
      m_instret = (m_instret + 1) % WRAP;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 0;
      start = 0;
      mem_ready = 0;
      #1;
      checks++;
      if (sample() !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b required=0", sample());
      end
      m_instret = 0;
      m_cause   = 0;
      where     = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic idle_cycle(input bit st, input bit hl);
      obs_t e;
      begin_cycle();
      start = st;
      halt  = hl;
      e = base();
      e.busy = 0;
      expect_now(e);
      if (st && !hl) where = 1;
   endtask

   task automatic trap_cycles(input int n);
      obs_t e;
      repeat (n) begin
         begin_cycle();
         e = base();
         e.trap = 1;
         expect_now(e);
      end
   endtask

   // Stalled request cycles; ok=0 means the wait ran out and the core trapped.
   task automatic req_wait(input int wt, input bit we, output bit ok);
      obs_t e;
      ok = 1;
      for (int k = 0; k < wt && k < int'(TO); k++) begin
         begin_cycle();
         mem_ready = 0;
         e = base();
         e.mem_req = 1;
         e.mem_we  = we;
         expect_now(e);
      end
      if (wt >= int'(TO)) begin
         ok = 0;
         m_cause = 2;
         where = 2;
      end
   endtask

   task automatic run_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rdv, input int fwait, input int mwait,
                           input bit bt, input bit hend);
      obs_t  e;
      bit    ok;
      kind_t k;
      k = kind_of(op);
      req_wait(fwait, 1'b0, ok);
      if (!ok) return;
      begin_cycle();
      mem_ready = 1;
      e = base();
      e.mem_req = 1;
      e.ir_we   = 1;
      expect_now(e);
      begin_cycle();
      opcode = op; funct3 = f3; funct7 = f7; rd = rdv;
      expect_now(base());
      if (k == K_ILL) begin
         m_cause = 1;
         where = 2;
         return;
      end
      begin_cycle();
      e = base();
      e.alu_op    = alu_of(k, f3, f7);
      e.alu_src_b = (k == K_I || k == K_LOAD || k == K_STORE);
      if (k == K_BRANCH) begin
         branch_taken = bt;
         halt = hend;
         e.pc_we  = 1;
         e.pc_sel = bt;
         expect_now(e);
         retire();
         where = hend ? 0 : 1;
         return;
      end
      expect_now(e);
      if (k == K_LOAD || k == K_STORE) begin
         req_wait(mwait, k == K_STORE, ok);
         if (!ok) return;
         begin_cycle();
         mem_ready = 1;
         e = base();
         e.mem_req = 1;
         e.mem_we  = (k == K_STORE);
         if (k == K_STORE) begin
            halt = hend;
            e.pc_we = 1;
            expect_now(e);
            retire();
            where = hend ? 0 : 1;
            return;
         end
         expect_now(e);
      end
      begin_cycle();
      halt = hend;
      e = base();
      e.reg_we = (rdv != 0);
      e.wb_sel = (k == K_LOAD);
      e.pc_we  = 1;
      expect_now(e);
      retire();
      where = hend ? 0 : 1;
   endtask

   task automatic rand_insn();
      logic [6:0] op;
      logic [6:0] ill [4];
      int sel, fw, mw;
      ill[0] = 7'b1111111; ill[1] = 7'b0110111; ill[2] = 7'b1101111; ill[3] = 7'b0000000;
      sel = int'($urandom_range(0, 15));
      if (sel == 0)       op = ill[$urandom_range(0, 3)];
      else if (sel <= 3)  op = 7'b0110011;
      else if (sel <= 6)  op = 7'b0010011;
      else if (sel <= 9)  op = 7'b0000011;
      else if (sel <= 12) op = 7'b0100011;
      else                op = 7'b1100011;
      fw = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      mw = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
      run_insn(op, 3'($urandom), 7'($urandom), 5'($urandom), fw, mw,
               1'($urandom), $urandom_range(0, 7) == 0);
   endtask

   initial begin
      rst_n = 0; start = 0; halt = 0; mem_ready = 0; branch_taken = 0;
      opcode = '0; funct3 = '0; funct7 = '0; rd = '0;
      do_reset();

      // R-type ADD, immediate ready
      idle_cycle(1, 0);
      run_insn(7'b0110011, 3'b000, 7'b0000000, 5'd5, 0, 0, 0, 0);
      @(posedge clk); #1;
      lit("t1_instret", int'(instret), 1);
      lit("t1_busy", int'(busy), 1);

      // LOAD rd=0 with three stalled MEM cycles
      run_insn(7'b0000011, 3'b010, 7'b0000000, 5'd0, 0, 3, 0, 0);
      @(posedge clk); #1;
      lit("t2_instret", int'(instret), 2);

      // taken BRANCH, then back to FETCH
      run_insn(7'b1100011, 3'b000, 7'b0000000, 5'd3, 0, 0, 1, 0);
      @(posedge clk); #1;
      lit("t3_instret", int'(instret), 3);
      lit("t3_fetch_req", int'(mem_req), 1);

      // ready on the final allowed fetch cycle: no trap
      run_insn(7'b0010011, 3'b101, 7'b0100000, 5'd7, TO - 1, 0, 0, 0);
      @(posedge clk); #1;
      lit("t5b_no_trap", int'(trap), 0);

      // illegal opcode traps; start/halt ignored afterwards
      run_insn(7'b1111111, 3'b000, 7'b0000000, 5'd1, 0, 0, 0, 0);
      trap_cycles(6);
      @(posedge clk); #1;
      lit("t4_cause", int'(trap_cause), 1);
      do_reset();

      // reset while a fetch request is pending, then fetch timeout
      idle_cycle(1, 0);
      do_reset();
      idle_cycle(1, 0);
      run_insn(7'b0110011, 3'b000, 7'b0000000, 5'd1, TO, 0, 0, 0);
      trap_cycles(3);
      @(posedge clk); #1;
      lit("t5_cause", int'(trap_cause), 2);
      do_reset();

      // halt beats start in IDLE; 16 retirements wrap instret; halt at STORE
      idle_cycle(1, 1);
      idle_cycle(1, 0);
      repeat (WRAP - 1)
         run_insn(7'b0010011, 3'($urandom), 7'($urandom), 5'($urandom), 0, 0, 0, 0);
      run_insn(7'b0100011, 3'b010, 7'b0000000, 5'd0, 0, 1, 0, 1);
      @(posedge clk); #1;
      lit("t6_busy", int'(busy), 0);
      lit("t6_wrap", int'(instret), 0);
      idle_cycle(0, 0);

      for (int n = 0; n < 400; n++) begin
         if (where == 0)
            idle_cycle(1'($urandom), 1'($urandom));
         else if (where == 1)
            rand_insn();
         else begin
            trap_cycles(2);
            do_reset();
         end
      end

      @(negedge clk); #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
